bilinear_sampler: RTL and testbench

- Sits directly downstream of the rotation address generator.
- Drives the 4-way address-select index (addr_count) into that stage, captures the four neighbouring VRAM pixels returned for one output pixel, and produces one filtered 24-bit RGB pixel with a valid pulse.
- Removes the aliasing and holes that come from nearest-neighbour lookup of rotated coordinates.

---
 rtl/graphics_pkg.sv | 21 ++
 rtl/channel_avg4.sv | 38 +++
 rtl/bilinear_sampler.sv | 152 +++++++++++++++
 tb/tb_bilinear_sampler.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/graphics_pkg.sv
// Shared types and constants for the rotation/sampling pixel pipeline.
package graphics_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] TAP_A = 2'd0;
   localparam logic [1:0] TAP_B = 2'd1;
   localparam logic [1:0] TAP_C = 2'd2;
   localparam logic [1:0] TAP_D = 2'd3;

   localparam int CH_W  = 8;
   localparam int R_LSB = 16;
   localparam int G_LSB = 8;
   localparam int B_LSB = 0;

endpackage

// File: rtl/channel_avg4.sv
// One colour channel of the 4-tap box filter: 10-bit accumulator and round-half-up divide by 4.
module channel_avg4 (
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       add_en,
   input  logic [7:0] data,
   output logic [7:0] avg
);

   logic [9:0] acc_r;
   logic [9:0] sum_s;

   // Accumulate captured taps; cleared at the start of each sample.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_r <= 10'd0;
      end else if (clr) begin
         acc_r <= 10'd0;
      end else if (add_en) begin
         acc_r <= acc_r + {2'b00, data};
      end else begin
         acc_r <= acc_r;
      end
   end

   // Average includes the tap being added this cycle so the final tap can be registered directly.
   always_comb begin
      sum_s = acc_r + 10'd2;
      if (add_en) begin
         sum_s = acc_r + {2'b00, data} + 10'd2;
      end else begin
         sum_s = acc_r + 10'd2;
      end
      avg = sum_s[9:2];
   end

endmodule

// File: rtl/bilinear_sampler.sv
// Fetches the four neighbouring VRAM pixels for one output pixel and emits their rounded average.
module bilinear_sampler
   import graphics_pkg::*;
#(
   parameter int READ_LATENCY = 2,
   parameter int SEL_LATENCY  = 1,
   parameter int PIX_W        = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             avg_en,
   input  logic [PIX_W-1:0] vram_data,
   output logic [2:0]       addr_count,
   output logic             busy,
   output logic [PIX_W-1:0] pixel_out,
   output logic             pixel_valid
);

   localparam int DEPTH = SEL_LATENCY + READ_LATENCY;

   state_t           state_r;
   logic [2:0]       addr_count_r;
   logic             busy_r;
   logic [PIX_W-1:0] pixel_out_r;
   logic             pixel_valid_r;
   logic             avg_en_r;
   logic [DEPTH-1:0] tag_valid_r;
   logic [1:0]       tag_tap_r [DEPTH];
   logic [PIX_W-1:0] tap0_r;
   logic [PIX_W-1:0] avg_s;
   logic             cap_s;
   logic [1:0]       cap_tap_s;
   logic             clr_s;

   assign cap_s     = tag_valid_r[DEPTH-1];
   assign cap_tap_s = tag_tap_r[DEPTH-1];
   assign clr_s     = (state_r == ST_IDLE) && start;

   channel_avg4 u_avg_r (
      .clk    (clk),
      .reset  (reset),
      .clr    (clr_s),
      .add_en (cap_s),
      .data   (vram_data[R_LSB +: CH_W]),
      .avg    (avg_s[R_LSB +: CH_W])
   );

   channel_avg4 u_avg_g (
      .clk    (clk),
      .reset  (reset),
      .clr    (clr_s),
      .add_en (cap_s),
      .data   (vram_data[G_LSB +: CH_W]),
      .avg    (avg_s[G_LSB +: CH_W])
   );

   channel_avg4 u_avg_b (
      .clk    (clk),
      .reset  (reset),
      .clr    (clr_s),
      .add_en (cap_s),
      .data   (vram_data[B_LSB +: CH_W]),
      .avg    (avg_s[B_LSB +: CH_W])
   );

   // Tag pipe mirrors the mux+VRAM delay so each tap's data is captured exactly when it arrives.
   always_ff @(posedge clk) begin
      if (reset) begin
         tag_valid_r <= {DEPTH{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            tag_tap_r[i] <= 2'd0;
         end
      end else begin
         tag_valid_r[0] <= (state_r == ST_ISSUE);
         tag_tap_r[0]   <= addr_count_r[1:0];
         for (int i = 1; i < DEPTH; i++) begin
            tag_valid_r[i] <= tag_valid_r[i-1];
            tag_tap_r[i]   <= tag_tap_r[i-1];
         end
      end
   end

   // Tap 0 kept separately for the pass-through mode.
   always_ff @(posedge clk) begin
      if (reset) begin
         tap0_r <= {PIX_W{1'b0}};
      end else if (cap_s && (cap_tap_s == TAP_A)) begin
         tap0_r <= vram_data;
      end else begin
         tap0_r <= tap0_r;
      end
   end

   // Sample sequencer with registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         addr_count_r  <= 3'd0;
         busy_r        <= 1'b0;
         pixel_out_r   <= {PIX_W{1'b0}};
         pixel_valid_r <= 1'b0;
         avg_en_r      <= 1'b0;
      end else begin
         pixel_valid_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  state_r      <= ST_ISSUE;
                  avg_en_r     <= avg_en;
                  busy_r       <= 1'b1;
                  addr_count_r <= {1'b0, TAP_A};
               end
            end
            ST_ISSUE: begin
               case (addr_count_r[1:0])
                  TAP_A: addr_count_r <= {1'b0, TAP_B};
                  TAP_B: addr_count_r <= {1'b0, TAP_C};
                  TAP_C: addr_count_r <= {1'b0, TAP_D};
                  TAP_D: begin
                     addr_count_r <= {1'b0, TAP_A};
                     state_r      <= ST_DRAIN;
                  end
                  default: addr_count_r <= 3'd0;
               endcase
            end
            ST_DRAIN: begin
               if (cap_s && (cap_tap_s == TAP_D)) begin
                  state_r       <= ST_DONE;
                  pixel_valid_r <= 1'b1;
                  pixel_out_r   <= avg_en_r ? avg_s : tap0_r;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r      <= ST_IDLE;
               busy_r       <= 1'b0;
               addr_count_r <= 3'd0;
            end
         endcase
      end
   end

   assign addr_count  = addr_count_r;
   assign busy        = busy_r;
   assign pixel_out   = pixel_out_r;
   assign pixel_valid = pixel_valid_r;

endmodule

// File: tb/tb_bilinear_sampler.sv
// Scoreboard bench: two samplers (READ_LATENCY 2 and 3) against a behavioural reference model.
module tb_bilinear_sampler;

   localparam int D0 = 1 + 2;
   localparam int D1 = 1 + 3;

   logic        clk = 1'b0;
   logic        reset, start, avg_en;
   logic [23:0] vram0, vram1;
   logic [2:0]  addr0, addr1;
   logic        busy0, busy1, pv0, pv1;
   logic [23:0] pix0, pix1;

   bilinear_sampler #(.READ_LATENCY(2), .SEL_LATENCY(1), .PIX_W(24)) dut0 (
      .clk(clk), .reset(reset), .start(start), .avg_en(avg_en), .vram_data(vram0),
      .addr_count(addr0), .busy(busy0), .pixel_out(pix0), .pixel_valid(pv0));

   bilinear_sampler #(.READ_LATENCY(3), .SEL_LATENCY(1), .PIX_W(24)) dut1 (
      .clk(clk), .reset(reset), .start(start), .avg_en(avg_en), .vram_data(vram1),
      .addr_count(addr1), .busy(busy1), .pixel_out(pix1), .pixel_valid(pv1));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [23:0] pix;
   } exp_t;

   exp_t        q0[$];
   exp_t        q1[$];
   logic [23:0] pend [4];
   logic [23:0] tbl  [2][4];
   int          acc_c   [2];
   int          abort_c [2];
   int          free_c  [2];
   int          hist    [2][16];
   int          compared = 0;
   int          mismatched = 0;
   bit          mon_on = 1'b0;

   function automatic logic [23:0] ref_pix(input logic ae, input logic [23:0] a, input logic [23:0] b,
                                           input logic [23:0] c, input logic [23:0] d);
      logic [23:0] r;
      int          sum;
      if (!ae) return a;
      for (int ch = 0; ch < 3; ch++) begin
         sum = int'(a[8*ch +: 8]) + int'(b[8*ch +: 8]) + int'(c[8*ch +: 8]) + int'(d[8*ch +: 8]);
         r[8*ch +: 8] = 8'((sum + 2) / 4);
      end
      return r;
   endfunction

   task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s dut%0d cycle %0d: got 0x%0h, expected 0x%0h", nm, inst, cyc, act, exp);
      end
   endtask

   // One clock of stimulus; also updates the reference model and the VRAM model.
   task automatic step(input logic st, input logic ae, input logic rs);
      int c, d, x;
      logic [23:0] px;
      @(negedge clk);
      c = cyc;
      hist[0][c % 16] = int'(addr0[1:0]);
      hist[1][c % 16] = int'(addr1[1:0]);
      for (int i = 0; i < 2; i++) begin
         d = (i == 0) ? D0 : D1;
         x = c - d;
         px = 24'($urandom);
         if (x >= acc_c[i] + 1 && x <= acc_c[i] + 4 && x <= abort_c[i] && x >= 0)
            px = tbl[i][hist[i][x % 16]];
         if (i == 0) vram0 = px; else vram1 = px;
      end
      start = st; avg_en = ae; reset = rs;
      for (int i = 0; i < 2; i++) begin
         d = (i == 0) ? D0 : D1;
         if (rs) begin
            if (c < acc_c[i] + 5 + d && abort_c[i] > c) abort_c[i] = c;
            if (i == 0) begin
               while (q0.size() > 0 && q0[$].cyc > c) void'(q0.pop_back());
            end else begin
               while (q1.size() > 0 && q1[$].cyc > c) void'(q1.pop_back());
            end
            free_c[i] = c + 1;
         end else if (st && c >= free_c[i]) begin
            for (int k = 0; k < 4; k++) tbl[i][k] = pend[k];
            acc_c[i]   = c;
            abort_c[i] = 1 << 30;
            free_c[i]  = c + 6 + d;
            px = ref_pix(ae, pend[0], pend[1], pend[2], pend[3]);
            if (i == 0) q0.push_back('{c + 5 + d, px});
            else        q1.push_back('{c + 5 + d, px});
         end
      end
   endtask

   task automatic set_pend(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c, input logic [23:0] d);
      pend[0] = a; pend[1] = b; pend[2] = c; pend[3] = d;
   endtask

   task automatic one_sample(input logic ae);
      step(1'b1, ae, 1'b0);
      repeat (12) step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic mon_pix(input int i, input int c, input logic pv, input logic [23:0] po);
      exp_t e;
      bit   have;
      have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (have) e = (i == 0) ? q0[0] : q1[0];
      if (pv) begin
         if (!have) begin
            chk("unexpected_pixel_valid", i, 32'(pv), 32'd0);
         end else begin
            if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            chk("pixel_valid_cycle", i, 32'(c), 32'(e.cyc));
            chk("pixel_out", i, 32'(po), 32'(e.pix));
         end
      end else if (have && e.cyc <= c) begin
         if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
         chk("missing_pixel_valid", i, 32'(pv), 32'd1);
      end
   endtask

   // Monitor: per-cycle control outputs and scoreboard for filtered pixels.
   initial begin
      int c, d, t, ab, ea;
      bit eb;
      forever begin
         @(negedge clk);
         if (mon_on) begin
            c = cyc;
            for (int i = 0; i < 2; i++) begin
               d  = (i == 0) ? D0 : D1;
               t  = acc_c[i];
               ab = abort_c[i];
               eb = (c >= t + 1) && (c <= t + 5 + d) && (c <= ab);
               ea = ((c >= t + 1) && (c <= t + 4) && (c <= ab)) ? (c - t - 1) : 0;
               chk("busy", i, 32'((i == 0) ? busy0 : busy1), 32'(eb));
               chk("addr_count", i, 32'((i == 0) ? addr0 : addr1), 32'(ea));
            end
            mon_pix(0, c, pv0, pix0);
            mon_pix(1, c, pv1, pix1);
         end
      end
   end

   initial begin
      start = 1'b0; avg_en = 1'b0; reset = 1'b1; vram0 = 24'h0; vram1 = 24'h0;
      for (int i = 0; i < 2; i++) begin
         acc_c[i] = -100; abort_c[i] = -100; free_c[i] = 0;
         for (int k = 0; k < 16; k++) hist[i][k] = 0;
         for (int k = 0; k < 4; k++) tbl[i][k] = 24'h0;
      end
      set_pend(24'h0, 24'h0, 24'h0, 24'h0);
      repeat (3) step(1'b0, 1'b0, 1'b1);
      mon_on = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      #1;
      chk("reset_pixel_out", 0, 32'(pix0), 32'h0);
      chk("reset_pixel_out", 1, 32'(pix1), 32'h0);
      chk("reset_pixel_valid", 0, 32'(pv0), 32'h0);

      // Directed: basic average, rounding, saturation-free max, pass-through, latency alignment.
      set_pend(24'h100000, 24'h200000, 24'h300000, 24'h400000); one_sample(1'b1);
      set_pend(24'h010000, 24'h010000, 24'h000000, 24'h000000); one_sample(1'b1);
      set_pend(24'h010000, 24'h000000, 24'h000000, 24'h000000); one_sample(1'b1);
      set_pend(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF); one_sample(1'b1);
      set_pend(24'h123456, 24'hFFFFFF, 24'h000000, 24'hABCDEF); one_sample(1'b0);
      set_pend(24'h000001, 24'h000002, 24'h000003, 24'h000006); one_sample(1'b1);

      // start held high: back-to-back samples.
      for (int n = 0; n < 40; n++) begin
         set_pend(24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom));
         step(1'b1, 1'b1, 1'b0);
      end
      repeat (12) step(1'b0, 1'b0, 1'b0);

      // start pulses while busy are ignored.
      set_pend(24'h0A0B0C, 24'h1A1B1C, 24'h2A2B2C, 24'h3A3B3C);
      step(1'b1, 1'b1, 1'b0);
      for (int n = 0; n < 8; n++) begin
         set_pend(24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom));
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end
      repeat (12) step(1'b0, 1'b0, 1'b0);

      // Reset at T+3 (with start also high), then a clean sample.
      set_pend(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      repeat (2) step(1'b0, 1'b0, 1'b0);
      set_pend(24'h040404, 24'h080808, 24'h0C0C0C, 24'h101010); one_sample(1'b1);

      // Random traffic with occasional resets.
      for (int n = 0; n < 300; n++) begin
         set_pend(24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom));
         step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 40) == 0));
      end
      repeat (15) step(1'b0, 1'b0, 1'b0);

      chk("pending_pixels", 0, 32'(q0.size()), 32'd0);
      chk("pending_pixels", 1, 32'(q1.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
